alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered successor to the 8-bit combinational ALU. It keeps the same
//   opcode map and adds a valid/ready handshake on input and output. Multiply and divide
//   are iterative multi-cycle operations, and the block reports zero and divide-by-zero
//   flags. It sits between the operand/opcode source (datapath control) and any consumer
//   that can apply backpressure.
// PARAMETERS
//   WIDTH   8   operand and result width in bits (>=2)
// PORTS
//   clk          in   1      system clock; all state updates on rising edge
//   rst_n        in   1      reset, asynchronous, active-low
//   in_valid     in   1      operands/opcode valid
//   in_ready     out  1      block can accept a new operation
//   a            in   WIDTH  first operand (unsigned)
//   b            in   WIDTH  second operand (unsigned)
//   op           in   4      opcode
//   out_valid    out  1      result/flags valid
//   out_ready    in   1      consumer accepts result
//   result       out  WIDTH  operation result
//   carry        out  1      carry/borrow/overflow flag (see below)
//   zero         out  1      result == 0
//   div_by_zero  out  1      set for DIV with b == 0
// BEHAVIOUR
//   Clock and reset:
//   - One clock domain: clk. Reset rst_n is asynchronous and active-low.
//   - Reset: FSM enters IDLE; in_ready=1; out_valid=0; result=0; carry=0; zero=0;
//     div_by_zero=0.
//   - Reset asserted mid-operation aborts the operation. No output pulse follows.
//   Handshake:
//   - Accept on the rising edge where in_valid && in_ready. a, b and op are captured then.
//     Later input changes are ignored until the next acceptance.
//   - in_ready = (state==IDLE). At most one operation is in flight.
//   - While out_valid && !out_ready, result and all flags hold stable.
//   - Output transfer on out_valid && out_ready; the next cycle the FSM is in IDLE.
//   - Peak throughput: one operation per (latency+1) cycles.
//   FSM states:
//   - IDLE -> EXEC on accept, for MUL, or for DIV with b!=0.
//   - IDLE -> DONE on accept, for all other opcodes and for DIV with b==0.
//   - EXEC -> DONE after WIDTH iteration cycles (counter WIDTH-1 down to 0).
//   - DONE -> IDLE on out_ready. out_valid = (state==DONE).
//   Latency (accept edge to first edge with out_valid=1):
//   - Single-cycle ops: 1 cycle.
//   - MUL, and DIV with b!=0: WIDTH+1 cycles.
//   Opcodes (all arithmetic unsigned, modulo 2^WIDTH):
//   - 0000 ADD: result=a+b; carry=bit WIDTH of the (WIDTH+1)-bit sum.
//   - 0001 SUB: result=a-b; carry=borrow (a<b).
//   - 0010 MUL: shift-add, one bit per cycle, 2*WIDTH-bit internal product;
//     result=low WIDTH bits; carry=1 if high WIDTH bits != 0.
//   - 0011 DIV: restoring divide, one quotient bit per cycle; result=floor(a/b); carry=0.
//     For b==0: result=all ones, div_by_zero=1, carry=0, 1-cycle latency.
//   - 1000 AND, 1001 OR, 1010 XOR: bitwise; carry=0.
//   - Any other opcode: treated as ADD, including carry.
//   Flags:
//   - div_by_zero=0 for every case except DIV with b==0.
//   - zero is computed from the final result for every opcode.
//   - Flags update only on the edge that enters DONE.
// TESTING (WIDTH=8)
//   1. ADD a=200,b=100 -> result=44, carry=1, zero=0; out_valid 1 cycle after accept.
//      SUB a=10,b=20 -> result=246, carry=1.
//   2. MUL a=15,b=17 -> result=255, carry=0; MUL a=20,b=20 -> result=144, carry=1;
//      out_valid exactly 9 cycles after accept; in_ready=0 throughout.
//   3. DIV a=100,b=7 -> result=14, 9-cycle latency; DIV a=5,b=0 -> result=255,
//      div_by_zero=1, 1-cycle latency; AND a=0xF0,b=0x0F -> result=0, zero=1.
//   4. Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable,
//      in_ready=0, and a new in_valid is ignored; release -> IDLE next cycle.
//   5. Assert rst_n low 4 cycles into a DIV -> outputs reach reset values immediately
//      (asynchronous); no out_valid after release; next ADD 1+1 -> 2.
//   6. Change a/b/op during EXEC -> result matches the captured operands;
//      op=0111 with 255+1 -> result=0, carry=1, zero=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/opcode request and result/flag response channels of alu_seq.
// Each direction has its own valid/ready handshake.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. MUL (shift-add)
// and DIV (restoring) take WIDTH iterations; all other ops finish in one cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010,
                         OP_DIV = 4'b0011, OP_AND = 4'b1000, OP_OR  = 4'b1001,
                         OP_XOR = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor
  logic [2*WIDTH-1:0] acc;        // {partial product, multiplier} or {remainder, quotient}
  logic               in_ready_q, out_valid_q, carry_q, zero_q, dbz_q;
  logic [WIDTH-1:0]   result_q;

  // One shift-add / restoring-divide step on the current accumulator.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   exec_nxt;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, opnd};
    div_diff = div_sh[WIDTH-1:0] - opnd;
    if (is_mul) exec_nxt = {mul_sum, acc[WIDTH-1:1]};
    else        exec_nxt = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  end

  // Single-cycle results, evaluated on the live inputs at accept time.
  logic [WIDTH:0]   sc_sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_dbz, go_exec;

  always_comb begin
    sc_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    sc_res   = sc_sum[WIDTH-1:0];
    sc_carry = sc_sum[WIDTH];
    sc_dbz   = 1'b0;
    go_exec  = 1'b0;
    case (bus.op)
      OP_SUB: begin sc_res = bus.a - bus.b; sc_carry = bus.a < bus.b; end
      OP_MUL: go_exec = 1'b1;
      OP_DIV: begin
        sc_res   = '1;
        sc_carry = 1'b0;
        sc_dbz   = (bus.b == '0);
        go_exec  = (bus.b != '0);
      end
      OP_AND: begin sc_res = bus.a & bus.b; sc_carry = 1'b0; end
      OP_OR:  begin sc_res = bus.a | bus.b; sc_carry = 1'b0; end
      OP_XOR: begin sc_res = bus.a ^ bus.b; sc_carry = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_mul      <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          in_ready_q <= 1'b0;
          if (go_exec) begin
            state  <= EXEC;
            cnt    <= CW'(WIDTH - 1);
            is_mul <= (bus.op == OP_MUL);
            opnd   <= bus.b;
            acc    <= {{WIDTH{1'b0}}, bus.a};
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= sc_res;
            carry_q     <= sc_carry;
            zero_q      <= (sc_res == '0);
            dbz_q       <= sc_dbz;
          end
        end
        EXEC: begin
          acc <= exec_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= exec_nxt[WIDTH-1:0];
            carry_q     <= is_mul & (|exec_nxt[2*WIDTH-1:WIDTH]);
            zero_q      <= (exec_nxt[WIDTH-1:0] == '0);
            dbz_q       <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed literal cases plus random ops
// against an arithmetic reference model and a result queue.
module tb_alu_seq;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, d;
    int           lat;
  } exp_t;

  logic clk, rst_n;
  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [W-1:0] last_res;
  logic last_c, last_z, last_d;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic [3:0] o);
    exp_t e;
    int   s;
    e.c = 1'b0; e.d = 1'b0; e.lat = 1;
    case (o)
      4'd1: begin s = int'(x) - int'(y); e.res = s[W-1:0]; e.c = (x < y); end
      4'd2: begin
        s = int'(x) * int'(y);
        e.res = s[W-1:0]; e.c = (s >= (1 << W)); e.lat = W + 1;
      end
      4'd3: if (y == 0) begin e.res = '1; e.d = 1'b1; end
            else begin s = int'(x) / int'(y); e.res = s[W-1:0]; e.lat = W + 1; end
      4'd8:  e.res = x & y;
      4'd9:  e.res = x | y;
      4'd10: e.res = x ^ y;
      default: begin s = int'(x) + int'(y); e.res = s[W-1:0]; e.c = s[W]; end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Compare process: any cycle with out_valid must show the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        check("mon_result", bus.result, exp_q[0].res);
        check("mon_carry", bus.carry, exp_q[0].c);
        check("mon_zero", bus.zero, exp_q[0].z);
        check("mon_dbz", bus.div_by_zero, exp_q[0].d);
        check("mon_in_ready", bus.in_ready, 0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [3:0] opi, input int bp, input bit scramble);
    exp_t e;
    int   n, lat;
    e = model(ai, bi, opi);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.out_ready = (bp == 0);
    bus.in_valid = 1'b1; bus.a = ai; bus.b = bi; bus.op = opi;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 4'($urandom);
    end
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      check("in_ready_busy", bus.in_ready, 0);
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, e.lat);
    last_res = bus.result; last_c = bus.carry; last_z = bus.zero; last_d = bus.div_by_zero;
    repeat (bp) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 4'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_xfer", bus.in_ready, 1);
    check("out_valid_drop", bus.out_valid, 0);
  endtask

  initial begin
    exp_t m;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", {bus.carry, bus.zero, bus.div_by_zero}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model against hand-computed values.
    m = model(8'd200, 8'd100, 4'd0); check("model_add", {m.c, m.res}, 256 + 44);
    m = model(8'd20, 8'd20, 4'd2);   check("model_mul", {m.c, m.res}, 256 + 144);
    m = model(8'd100, 8'd7, 4'd3);   check("model_div", m.res, 14);

    run_op(8'd200, 8'd100, 4'b0000, 0, 0);
    check("add_res", last_res, 44); check("add_c", last_c, 1); check("add_z", last_z, 0);
    run_op(8'd10, 8'd20, 4'b0001, 0, 0);
    check("sub_res", last_res, 246); check("sub_c", last_c, 1);
    run_op(8'd15, 8'd17, 4'b0010, 0, 0);
    check("mul1_res", last_res, 255); check("mul1_c", last_c, 0);
    run_op(8'd20, 8'd20, 4'b0010, 0, 0);
    check("mul2_res", last_res, 144); check("mul2_c", last_c, 1);
    run_op(8'd100, 8'd7, 4'b0011, 0, 0);
    check("div_res", last_res, 14); check("div_dbz", last_d, 0);
    run_op(8'd5, 8'd0, 4'b0011, 0, 0);
    check("div0_res", last_res, 255); check("div0_dbz", last_d, 1); check("div0_c", last_c, 0);
    run_op(8'hF0, 8'h0F, 4'b1000, 0, 0);
    check("and_res", last_res, 0); check("and_z", last_z, 1);
    run_op(8'd77, 8'd3, 4'b0010, 5, 0);
    check("bp_mul_res", last_res, 231);
    run_op(8'd250, 8'd9, 4'b0011, 0, 1);
    check("scramble_div_res", last_res, 27);
    run_op(8'd255, 8'd1, 4'b0111, 0, 0);
    check("op7_res", last_res, 0); check("op7_c", last_c, 1); check("op7_z", last_z, 1);

    // Reset in the middle of a DIV.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 8'd100; bus.b = 8'd7; bus.op = 4'b0011;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; check("no_out_after_rst", bus.out_valid, 0); end
    run_op(8'd1, 8'd1, 4'b0000, 0, 0);
    check("post_rst_add", last_res, 2);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] o;
      logic [W-1:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(x, y, o, $urandom_range(0, 3), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
